// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-like arbiter: size encodings and width helpers.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // A single master still needs a one-bit channel id so the FIFO has a slot.
    function automatic int chid_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_arb_order_fifo.sv
// In-order FIFO of channel ids for accepted-but-unanswered requests.
module sram_arb_order_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic [ID_W-1:0]  head_id,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave SRAM-like arbiter with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             m_req,
    input  logic [NCH-1:0]             m_wr,
    input  logic [2*NCH-1:0]           m_size,
    input  logic [NCH*DATA_W/8-1:0]    m_wstrb,
    input  logic [NCH*ADDR_W-1:0]      m_addr,
    input  logic [NCH*DATA_W-1:0]      m_wdata,
    output logic [NCH-1:0]             m_addr_ok,
    output logic [NCH-1:0]             m_data_ok,
    output logic [NCH*DATA_W-1:0]      m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    input  logic [DATA_W-1:0]          s_rdata
);

    localparam int ID_W   = chid_w(NCH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  lock_id;
    logic [ID_W-1:0]  head_id;
    logic             lock;
    logic             accept;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

`ifdef SRAM_ARB_RR_EN
    logic [ID_W-1:0] rr_last;
    logic            found;

    // Indices above rr_last first, then wrap to the lowest requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && m_req[i] && (ID_W'(i) > rr_last)) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && m_req[i]) begin
                winner = ID_W'(i);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= ID_W'(NCH - 1);
        end else if (accept) begin
            rr_last <= grant;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`endif

    assign grant  = lock ? lock_id : winner;
    assign s_req  = (|m_req) && !full && !reset;
    assign accept = s_req && s_addr_ok;
    assign pop    = s_data_ok && !empty && !reset;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == ID_W'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_wstrb = m_wstrb[STRB_W*i +: STRB_W];
                s_addr  = m_addr[ADDR_W*i +: ADDR_W];
                s_wdata = m_wdata[DATA_W*i +: DATA_W];
            end
            m_addr_ok[i] = accept && (grant == ID_W'(i));
            m_data_ok[i] = pop && (head_id == ID_W'(i));
        end
    end

    assign m_rdata = {NCH{s_rdata}};

    // A stalled request pins the grant so its fields stay stable until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (s_req && !s_addr_ok) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end else if (accept) begin
            lock    <= 1'b0;
        end
    end

    sram_arb_order_fifo #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_order_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant),
        .pop     (pop),
        .head_id (head_id),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(s_data_ok && empty))
                else $warning("sram_like_arbiter: s_data_ok with no outstanding request ignored");
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a DEPTH=4 instance and a DEPTH=2 instance for the full case.
module tb_sram_like_arbiter;
    import sram_arb_pkg::*;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] ADDR0  = 32'h0000_1000;
    localparam logic [31:0] ADDR1  = 32'h0000_2004;
    localparam logic [31:0] WDATA0 = 32'hA0A0_0000;
    localparam logic [31:0] WDATA1 = 32'hB1B1_1111;
    localparam logic [31:0] RDATA  = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [7:0]  m_wstrb;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [31:0] s_rdata;

    logic [1:0]  m_req, m_addr_ok, m_data_ok;
    logic [63:0] m_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;

    logic [1:0]  f_m_req, f_m_addr_ok, f_m_data_ok;
    logic [63:0] f_m_rdata;
    logic        f_s_req, f_s_wr, f_s_addr_ok, f_s_data_ok;
    logic [1:0]  f_s_size;
    logic [3:0]  f_s_wstrb;
    logic [31:0] f_s_addr, f_s_wdata;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    sram_like_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(2)) u_dut_full (
        .clk(clk), .reset(reset),
        .m_req(f_m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata),
        .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_wstrb(f_s_wstrb),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_addr_ok(f_s_addr_ok), .s_data_ok(f_s_data_ok), .s_rdata(s_rdata)
    );

    task automatic drive_idle;
        m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        f_m_req = 2'b00; f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0;
    endtask

    task automatic apply_reset;
        @(negedge clk); reset = 1'b1; drive_idle();
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        f_m_req = 2'b11; f_s_addr_ok = 1'b1; f_s_data_ok = 1'b1;
        #1;
        vectors++;
        if (s_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_req: got %b expected 0", s_req); end
        vectors++;
        if (m_addr_ok !== 2'b00) begin errors++; $display("[TB] FAIL reset_addr_ok: got %b expected 00", m_addr_ok); end
        vectors++;
        if (m_data_ok !== 2'b00) begin errors++; $display("[TB] FAIL reset_data_ok: got %b expected 00", m_data_ok); end
        vectors++;
        if (f_s_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_s_req: got %b expected 0", f_s_req); end
        @(negedge clk); reset = 1'b0; drive_idle();
        #1;
        vectors++;
        if (s_req !== 1'b0 || m_data_ok !== 2'b00) begin
            errors++; $display("[TB] FAIL idle_after_reset: got s_req=%b data_ok=%b expected 0/00", s_req, m_data_ok);
        end
    endtask

    task automatic test_arbitration;
        logic [1:0]  exp_ok;
        logic [1:0]  prev_ok;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_size;
        int          g;
        apply_reset();
        prev_ok = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = (c > 0);
            #1;
            g         = RR ? (c % 2) : 0;
            exp_ok    = (g == 0) ? 2'b01 : 2'b10;
            exp_addr  = (g == 0) ? ADDR0 : ADDR1;
            exp_wdata = (g == 0) ? WDATA0 : WDATA1;
            exp_size  = (g == 0) ? SZ_WORD : SZ_BYTE;
            vectors++;
            if (m_addr_ok !== exp_ok) begin
                errors++; $display("[TB] FAIL arb_addr_ok[%0d]: got %b expected %b", c, m_addr_ok, exp_ok);
            end
            vectors++;
            if (s_addr !== exp_addr || s_wdata !== exp_wdata || s_size !== exp_size) begin
                errors++; $display("[TB] FAIL arb_fields[%0d]: got %h/%h/%0d expected %h/%h/%0d",
                                   c, s_addr, s_wdata, s_size, exp_addr, exp_wdata, exp_size);
            end
            vectors++;
            if (m_data_ok !== prev_ok) begin
                errors++; $display("[TB] FAIL arb_data_ok[%0d]: got %b expected %b", c, m_data_ok, prev_ok);
            end
            prev_ok = exp_ok;
        end
        @(negedge clk);
        m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = RDATA;
        #1;
        vectors++;
        if (m_data_ok !== prev_ok || s_req !== 1'b0) begin
            errors++; $display("[TB] FAIL arb_drain: got data_ok=%b s_req=%b expected %b/0", m_data_ok, s_req, prev_ok);
        end
        vectors++;
        if (m_rdata !== {RDATA, RDATA}) begin
            errors++; $display("[TB] FAIL rdata_broadcast: got %h expected %h", m_rdata, {RDATA, RDATA});
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_lock;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m_req = (c == 2) ? 2'b11 : 2'b10; s_addr_ok = 1'b0;
            #1;
            vectors++;
            if (s_req !== 1'b1 || m_addr_ok !== 2'b00 || s_addr !== ADDR1) begin
                errors++; $display("[TB] FAIL lock_hold[%0d]: got s_req=%b ok=%b addr=%h expected 1/00/%h",
                                   c, s_req, m_addr_ok, s_addr, ADDR1);
            end
        end
        @(negedge clk); m_req = 2'b11; s_addr_ok = 1'b1; #1;
        vectors++;
        if (m_addr_ok !== 2'b10 || s_wr !== 1'b0) begin
            errors++; $display("[TB] FAIL lock_handshake: got ok=%b wr=%b expected 10/0", m_addr_ok, s_wr);
        end
        @(negedge clk); m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b1; #1;
        vectors++;
        if (m_addr_ok !== 2'b01 || m_data_ok !== 2'b10) begin
            errors++; $display("[TB] FAIL lock_release: got ok=%b data_ok=%b expected 01/10", m_addr_ok, m_data_ok);
        end
        @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; #1;
        vectors++;
        if (m_data_ok !== 2'b01) begin
            errors++; $display("[TB] FAIL lock_resp0: got %b expected 01", m_data_ok);
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_full;
        // columns: m_req, addr_ok, data_ok, expected s_req, addr_ok, data_ok
        logic [1:0] req_v   [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        logic       aok_v   [8] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        logic       dok_v   [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
        logic       e_sreq  [8] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
        logic [1:0] e_aok   [8] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic [1:0] e_dok   [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            f_m_req = req_v[c]; f_s_addr_ok = aok_v[c]; f_s_data_ok = dok_v[c];
            #1;
            vectors++;
            if (f_s_req !== e_sreq[c] || f_m_addr_ok !== e_aok[c] || f_m_data_ok !== e_dok[c]) begin
                errors++; $display("[TB] FAIL full[%0d]: got s_req=%b ok=%b data_ok=%b expected %b/%b/%b",
                                   c, f_s_req, f_m_addr_ok, f_m_data_ok, e_sreq[c], e_aok[c], e_dok[c]);
            end
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_out_of_range;
        logic [1:0] exp_ok;
        apply_reset();
        @(negedge clk); s_data_ok = 1'b1; #1;
        vectors++;
        if (m_data_ok !== 2'b00) begin
            errors++; $display("[TB] FAIL empty_data_ok: got %b expected 00", m_data_ok);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b0; #1;
            vectors++;
            if (m_addr_ok !== 2'b01) begin
                errors++; $display("[TB] FAIL prefill[%0d]: got %b expected 01", c, m_addr_ok);
            end
        end
        @(negedge clk); reset = 1'b1; m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b1; #1;
        vectors++;
        if (s_req !== 1'b0 || m_addr_ok !== 2'b00 || m_data_ok !== 2'b00) begin
            errors++; $display("[TB] FAIL mid_reset: got s_req=%b ok=%b data_ok=%b expected 0/00/00",
                               s_req, m_addr_ok, m_data_ok);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); reset = 1'b0; m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; #1;
            vectors++;
            if (m_data_ok !== 2'b00) begin
                errors++; $display("[TB] FAIL dropped_resp[%0d]: got %b expected 00", c, m_data_ok);
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b0; #1;
            exp_ok = (c < 4) ? 2'b01 : 2'b00;
            vectors++;
            if (m_addr_ok !== exp_ok) begin
                errors++; $display("[TB] FAIL refill[%0d]: got %b expected %b", c, m_addr_ok, exp_ok);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; #1;
            vectors++;
            if (m_data_ok !== 2'b01) begin
                errors++; $display("[TB] FAIL drain[%0d]: got %b expected 01", c, m_data_ok);
            end
        end
        @(negedge clk); drive_idle();
    endtask

    initial begin
        drive_idle();
        m_wr    = 2'b01;
        m_size  = {SZ_BYTE, SZ_WORD};
        m_wstrb = 8'h1F;
        m_addr  = {ADDR1, ADDR0};
        m_wdata = {WDATA1, WDATA0};
        s_rdata = 32'h0;
        $display("[TB] start, round-robin=%0d", RR);
        test_reset();
        test_arbitration();
        test_lock();
        test_full();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
